// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-FIFO read side plus VGA display outputs of the timing generator.
//   fifo_empty    - pixel FIFO empty flag (into the generator)
//   rd_fifo       - FIFO read enable, one per visible pixel
//   hsync/vsync   - active-low syncs, aligned with FIFO output data
//   blank         - high outside the visible region
//   pixel_x/y     - coordinates of the pixel on the data bus (0 when blank)
//   frame_start   - pulse with the read of pixel (0,0)
//   underflow     - sticky empty-read flag; underflow_cnt saturating count
interface vga_timing_gen_if;
    logic        fifo_empty;
    logic        rd_fifo;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;
    modport master(
        input  fifo_empty,
        output rd_fifo, hsync, vsync, blank, pixel_x, pixel_y, frame_start, underflow, underflow_cnt
    );
    modport slave(
        output fifo_empty,
        input  rd_fifo, hsync, vsync, blank, pixel_x, pixel_y, frame_start, underflow, underflow_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock VGA timing generator and pixel FIFO reader with underflow tracking.
//   clk  - pixel clock
//   rst  - synchronous active-high reset
//   bus  - vga_timing_gen_if.master: FIFO read side and display outputs
//   H_* / V_* set the raster (totals must be <= 1024); READ_LAT (1..4) is the
//   FIFO read-to-data latency applied to the display-side outputs.
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int READ_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_END  = 10'(H_VIS);
    localparam logic [9:0] V_END  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic       hs0, vs0;
    logic [READ_LAT-1:0]       vis_d, hs_d, vs_d;
    logic [READ_LAT-1:0][9:0]  x_d, y_d;

    always_comb begin
        h_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
        v_nxt = (h_cnt != H_LAST) ? v_cnt : (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        hs0   = !(h_cnt >= HS_BEG && h_cnt <= HS_END);
        vs0   = !(v_cnt >= VS_BEG && v_cnt <= VS_END);
    end

    // rd_fifo/frame_start are decoded from the next count so they line up with
    // the registered counters; the delay line then carries them to the DAC side.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt             <= H_LAST;
            v_cnt             <= V_LAST;
            bus.rd_fifo       <= 1'b0;
            bus.frame_start   <= 1'b0;
            vis_d             <= '0;
            hs_d              <= '1;
            vs_d              <= '1;
            x_d               <= '0;
            y_d               <= '0;
            bus.underflow     <= 1'b0;
            bus.underflow_cnt <= '0;
        end else begin
            h_cnt           <= h_nxt;
            v_cnt           <= v_nxt;
            bus.rd_fifo     <= (h_nxt < H_END) && (v_nxt < V_END);
            bus.frame_start <= (h_nxt == '0) && (v_nxt == '0);
            for (int i = READ_LAT - 1; i > 0; i--) begin
                vis_d[i] <= vis_d[i-1];
                hs_d[i]  <= hs_d[i-1];
                vs_d[i]  <= vs_d[i-1];
                x_d[i]   <= x_d[i-1];
                y_d[i]   <= y_d[i-1];
            end
            vis_d[0] <= bus.rd_fifo;
            hs_d[0]  <= hs0;
            vs_d[0]  <= vs0;
            x_d[0]   <= h_cnt;
            y_d[0]   <= v_cnt;
            // Reads are never suppressed; an empty read is only recorded.
            if (bus.rd_fifo && bus.fifo_empty) begin
                bus.underflow <= 1'b1;
                if (bus.underflow_cnt != 16'hFFFF)
                    bus.underflow_cnt <= bus.underflow_cnt + 16'd1;
            end
        end
    end

    assign bus.blank   = !vis_d[READ_LAT-1];
    assign bus.hsync   = hs_d[READ_LAT-1];
    assign bus.vsync   = vs_d[READ_LAT-1];
    assign bus.pixel_x = vis_d[READ_LAT-1] ? x_d[READ_LAT-1] : '0;
    assign bus.pixel_y = vis_d[READ_LAT-1] ? y_d[READ_LAT-1] : '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen at default timing (READ_LAT=1) and a small raster (READ_LAT=3).
module tb_vga_timing_gen;
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 2;
    localparam int SLAT = 3;
    localparam int STH = SHV + SHF + SHS + SHB;
    localparam int STV = SVV + SVF + SVS + SVB;
    localparam int SFRAME = STH * STV;
    localparam int NV = 19;

    typedef struct {
        int          cyc;
        logic        empty;
        logic [4:0]  f;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        uf;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int         due;
        logic [9:0] x;
        logic [9:0] y;
    } sb_t;

    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if bus_d();
    vga_timing_gen_if bus_s();

    vga_timing_gen dut_d (.clk(clk), .rst(rst_d), .bus(bus_d));
    vga_timing_gen #(
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .READ_LAT(SLAT)
    ) dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

    int checks = 0;
    int failures = 0;
    vec_t tbl[NV];
    sb_t q[$];
    int k = 0;
    int ti, rd_n, hs_n, vs_n, last_fs;

    localparam logic [63:0] RST_D = 64'({5'b01110, 10'd0, 10'd0, 1'b0, 16'd0});
    localparam logic [63:0] RST_S = 64'({5'b01110, 10'd0, 10'd0});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int c, input logic e, input logic [4:0] f, input int px,
                                input int py, input logic uf, input int cnt);
        vec_t r;
        r.cyc = c;
        r.empty = e;
        r.f = f;
        r.px = 10'(px);
        r.py = 10'(py);
        r.uf = uf;
        r.cnt = 16'(cnt);
        return r;
    endfunction

    function automatic logic [63:0] pack_d();
        return 64'({bus_d.rd_fifo, bus_d.blank, bus_d.hsync, bus_d.vsync, bus_d.frame_start,
                    bus_d.pixel_x, bus_d.pixel_y, bus_d.underflow, bus_d.underflow_cnt});
    endfunction

    function automatic logic [63:0] pack_s();
        return 64'({bus_s.rd_fifo, bus_s.blank, bus_s.hsync, bus_s.vsync, bus_s.frame_start,
                    bus_s.pixel_x, bus_s.pixel_y});
    endfunction

    // Expected small-raster outputs on cycle t after release (t=1 is the first edge).
    function automatic logic [63:0] model_s(input int t);
        int h, v, td, hd, vd;
        logic rd, fs, vis, hs, vs;
        logic [9:0] px, py;
        h = (t - 1) % STH;
        v = ((t - 1) / STH) % STV;
        rd = (h < SHV) && (v < SVV);
        fs = (h == 0) && (v == 0);
        vis = 1'b0; hs = 1'b1; vs = 1'b1; px = '0; py = '0;
        td = t - SLAT;
        if (td >= 1) begin
            hd = (td - 1) % STH;
            vd = ((td - 1) / STH) % STV;
            vis = (hd < SHV) && (vd < SVV);
            hs = !(hd >= SHV + SHF && hd < SHV + SHF + SHS);
            vs = !(vd >= SVV + SVF && vd < SVV + SVF + SVS);
            if (vis) begin
                px = 10'(hd);
                py = 10'(vd);
            end
        end
        return 64'({rd, !vis, hs, vs, fs, px, py});
    endfunction

    task automatic step_s(input int c);
        sb_t e;
        check($sformatf("model_s@%0d", c), pack_s(), model_s(c));
        if (bus_s.rd_fifo) begin
            e.due = c + SLAT;
            e.x = 10'(k % SHV);
            e.y = 10'((k / SHV) % SVV);
            q.push_back(e);
            k++;
        end
        if (!bus_s.blank) begin
            check($sformatf("sb_depth@%0d", c), 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("sb_pixel@%0d", c), 64'({32'(c), bus_s.pixel_x, bus_s.pixel_y}),
                      64'({32'(e.due), e.x, e.y}));
            end
        end
    endtask

    initial begin
        bus_d.fifo_empty = 1'b0;
        bus_s.fifo_empty = 1'b0;
        tbl[0]  = mk(1,    1'b1, 5'b11111, 0,   0, 1'b0, 0);
        tbl[1]  = mk(2,    1'b1, 5'b10110, 0,   0, 1'b1, 1);
        tbl[2]  = mk(3,    1'b1, 5'b10110, 1,   0, 1'b1, 2);
        tbl[3]  = mk(4,    1'b0, 5'b10110, 2,   0, 1'b1, 3);
        tbl[4]  = mk(640,  1'b0, 5'b10110, 638, 0, 1'b1, 3);
        tbl[5]  = mk(641,  1'b0, 5'b00110, 639, 0, 1'b1, 3);
        tbl[6]  = mk(642,  1'b0, 5'b01110, 0,   0, 1'b1, 3);
        tbl[7]  = mk(657,  1'b0, 5'b01110, 0,   0, 1'b1, 3);
        tbl[8]  = mk(658,  1'b0, 5'b01010, 0,   0, 1'b1, 3);
        tbl[9]  = mk(753,  1'b0, 5'b01010, 0,   0, 1'b1, 3);
        tbl[10] = mk(754,  1'b0, 5'b01110, 0,   0, 1'b1, 3);
        tbl[11] = mk(800,  1'b0, 5'b01110, 0,   0, 1'b1, 3);
        tbl[12] = mk(801,  1'b0, 5'b11110, 0,   0, 1'b1, 3);
        tbl[13] = mk(802,  1'b0, 5'b10110, 0,   1, 1'b1, 3);
        tbl[14] = mk(803,  1'b0, 5'b10110, 1,   1, 1'b1, 3);
        tbl[15] = mk(1441, 1'b0, 5'b00110, 639, 1, 1'b1, 3);
        tbl[16] = mk(1442, 1'b0, 5'b01110, 0,   0, 1'b1, 3);
        tbl[17] = mk(1458, 1'b0, 5'b01010, 0,   0, 1'b1, 3);
        tbl[18] = mk(1600, 1'b0, 5'b01110, 0,   0, 1'b1, 3);

        repeat (5) @(negedge clk);
        check("reset_d", pack_d(), RST_D);
        check("reset_s", pack_s(), RST_S);

        // Default raster: line timing plus three empty reads at the start of the frame.
        bus_d.fifo_empty = 1'b1;
        rst_d = 1'b0;
        ti = 0; rd_n = 0; hs_n = 0;
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            if (ti < NV && tbl[ti].cyc == c) begin
                check($sformatf("vec_d@%0d", c), pack_d(),
                      64'({tbl[ti].f, tbl[ti].px, tbl[ti].py, tbl[ti].uf, tbl[ti].cnt}));
                bus_d.fifo_empty = tbl[ti].empty;
                ti++;
            end
            if (bus_d.rd_fifo) rd_n++;
            if (!bus_d.hsync) hs_n++;
        end
        check("vec_d_applied", 64'(ti), 64'(NV));
        check("rd_count_d", 64'(rd_n), 64'(1280));
        check("hs_low_d", 64'(hs_n), 64'(192));
        rst_d = 1'b1;
        @(negedge clk);
        check("reset_clear_d", pack_d(), RST_D);

        // Small raster, READ_LAT=3: two full frames, then a reset mid-frame.
        rst_s = 1'b0;
        rd_n = 0; vs_n = 0; last_fs = 0;
        for (int c = 1; c <= 2 * SFRAME + 2 * STH + 6; c++) begin
            @(negedge clk);
            step_s(c);
            if (bus_s.rd_fifo) rd_n++;
            if (!bus_s.vsync) vs_n++;
            if (c % SFRAME == 0 && c <= 2 * SFRAME) begin
                check($sformatf("rd_frame_s@%0d", c), 64'(rd_n), 64'(SHV * SVV));
                check($sformatf("vs_low_s@%0d", c), 64'(vs_n), 64'(SVS * STH));
                rd_n = 0; vs_n = 0;
            end
            if (bus_s.frame_start) begin
                if (last_fs > 0) check($sformatf("fs_period_s@%0d", c), 64'(c - last_fs), 64'(SFRAME));
                last_fs = c;
            end
        end
        rst_s = 1'b1;
        @(negedge clk);
        check("midreset_s", pack_s(), RST_S);
        q.delete();
        k = 0;
        rst_s = 1'b0;
        for (int c = 1; c <= 4 * STH; c++) begin
            @(negedge clk);
            step_s(c);
        end
        check("sb_drain", 64'(q.size()), 64'(0));
        check("uf_s", 64'({bus_s.underflow, bus_s.underflow_cnt}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
